uart_rx_gen: RTL
================

UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 1, meaning parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have port CLK50MHz  input  1  system clock; the block uses this single clock only.
REQ-006 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port RX  input  1  asynchronous serial line; idles high.
REQ-008 SHALL have port DATA_ACK  input  1  consumer acknowledge; clears DATA_VALID.
REQ-009 SHALL have port DATA  output  8  last good word; LSB is the first bit received; bits above DATA_BITS-1 are 0.
REQ-010 SHALL have port DATA_VALID  output  1  high while an unacknowledged good word is held.
REQ-011 SHALL have port PARITY_ERR  output  1  one-clock pulse on a parity mismatch.
REQ-012 SHALL have port FRAME_ERR  output  1  one-clock pulse when the stop bit samples low.
REQ-013 SHALL have port OVERRUN  output  1  one-clock pulse when a good word overwrites an unacknowledged word.
REQ-014 SHALL have port BUSY  output  1  high in every state except IDLE.

Function
REQ-015 SHALL pass RX through a 2-flop synchronizer; the sampler reads only the synchronized value.
REQ-016 SHALL generate a one-clock tick enable every DIV clocks, where DIV = round(CLK_FREQ/(16*BAUD)). The default gives 326. The counter is free-running.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK, with 16 ticks per bit and the sample point at tick 8 of each bit.
REQ-018 In IDLE, a synchronized high-to-low edge SHALL enter START and clear the tick-phase and bit counters.
REQ-019 In START, if the mid-bit sample is high, the block SHALL return to IDLE with no outputs asserted (false start). If it is low, the block SHALL enter DATA after 16 ticks.
REQ-020 DATA SHALL shift in DATA_BITS samples LSB-first. It SHALL then enter PARITY when PARITY != 0, and STOP otherwise.
REQ-021 PARITY SHALL compare the sample with the XOR of the payload (even) or its inverse (odd).
REQ-022 STOP SHALL end at the mid-bit sample, not at the bit end, to tolerate clock skew.
REQ-023 At the stop sample, if the stop bit is high and parity is good, the block SHALL load DATA and set DATA_VALID on the next clock edge (completion cycle), then go to IDLE.
REQ-024 If parity is bad at the stop sample, the block SHALL pulse PARITY_ERR in the completion cycle and leave DATA and DATA_VALID unchanged.
REQ-025 A low stop sample SHALL pulse FRAME_ERR in the completion cycle, leave DATA and DATA_VALID unchanged, and enter BREAK. A frame error takes precedence over parity: PARITY_ERR is not pulsed.
REQ-026 BREAK SHALL wait for a synchronized high on RX, then go to IDLE.
REQ-027 DATA_ACK high SHALL clear DATA_VALID on the next edge.
REQ-028 If a good word completes while DATA_VALID=1 and DATA_ACK=0, the block SHALL overwrite DATA, keep DATA_VALID=1, and pulse OVERRUN.
REQ-029 If a good word completes in the same cycle as DATA_ACK=1, the new word SHALL win: DATA_VALID stays 1 and OVERRUN is not pulsed.
REQ-030 Maximum latency SHALL be 3 clocks plus one tick period from the stop-bit mid-sample to DATA_VALID.

Reset
REQ-031 RESET low SHALL asynchronously force state IDLE, all counters to 0, synchronizer flops to 1, DATA=0x00, and DATA_VALID, PARITY_ERR, FRAME_ERR, OVERRUN and BUSY to 0.
REQ-032 A reset asserted mid-frame SHALL discard the partial word. After release, the block SHALL wait for the next falling edge.

Configuration
REQ-033 SHALL honour macro UART_RX_MAJORITY_VOTE_EN.
- When defined, each bit value (start, data, parity, stop) SHALL be the 2-of-3 majority of the samples at ticks 7, 8 and 9.
- When undefined, each bit value SHALL be the single sample at tick 8, and no voting logic is synthesized.

Verification (defaults: 50 MHz, 9600 baud, 8 data bits, even parity, DIV=326)
REQ-034 Send 0xA5 with parity 0 and stop 1 -> DATA=0xA5, DATA_VALID=1, no error pulses; DATA_ACK -> DATA_VALID=0 on the next clock.
REQ-035 Send 0xA5 with parity 1 -> one PARITY_ERR pulse; DATA holds its previous value. Send 0x3C with stop 0 held for 2 bit times -> one FRAME_ERR pulse, BUSY=1 until RX returns high.
REQ-036 Drive a 3 us low glitch on an idle line -> BUSY goes high then returns to 0 within 1 bit time; no VALID and no error pulses.
REQ-037 Send 0x11 then 0x22 with no DATA_ACK -> DATA=0x22, one OVERRUN pulse. Repeat with DATA_ACK coinciding with the completion of 0x22 -> no OVERRUN.
REQ-038 Assert RESET during data bit 4 of 0x7E, then release and send 0x81 -> only DATA=0x81 is reported.
REQ-039 With UART_RX_MAJORITY_VOTE_EN defined, force a one-tick high spike at tick 8 of data bit 0 of 0x00 -> DATA=0x00. With the macro undefined, the same stimulus gives DATA=0x01 and PARITY_ERR.

Source files
------------

// File: rtl/uart_rx_gen_if.sv
// Receiver-side bus of uart_rx_gen: serial line in, received word and status out.
interface uart_rx_gen_if;
    logic       RX;
    logic       DATA_ACK;
    logic [7:0] DATA;
    logic       DATA_VALID;
    logic       PARITY_ERR;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    // Line driver / word consumer side
    modport master (
        output RX,
        output DATA_ACK,
        input  DATA,
        input  DATA_VALID,
        input  PARITY_ERR,
        input  FRAME_ERR,
        input  OVERRUN,
        input  BUSY
    );

    // Receiver side
    modport slave (
        input  RX,
        input  DATA_ACK,
        output DATA,
        output DATA_VALID,
        output PARITY_ERR,
        output FRAME_ERR,
        output OVERRUN,
        output BUSY
    );
endinterface

// File: rtl/uart_rx_gen.sv
// UART receiver with 16x oversampling, optional parity, break detection and
// a one-word holding register with acknowledge/overrun handling.
// Optional macro UART_RX_MAJORITY_VOTE_EN: bit value is the 2-of-3 vote of the
// samples at ticks 7, 8 and 9 instead of the single tick-8 sample.
module uart_rx_gen #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 1
) (
    input  logic          CLK50MHz,
    input  logic          RESET,
    uart_rx_gen_if.slave  bus
);

    localparam int unsigned DIV      = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PH_W     = 4;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned LAST_PH  = 15;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned DECIDE_PH = 9;
`else
    localparam int unsigned DECIDE_PH = 8;
`endif
    localparam logic PAR_ODD = (PARITY == 32'd2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         rx_sync;
    logic               rx_s;
    logic               rx_prev;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [PH_W-1:0]    phase;
    logic [CNT_W-1:0]   bit_cnt;
    logic [7:0]         shreg;
    logic               par_bit;
    logic               par_ok;
    logic               bit_val;
    logic               decide;
    logic               bit_end;
    logic               frame_start;
    logic               done_good;
    logic               done_perr;
    logic               done_ferr;
    logic [7:0]         data_q;
    logic               valid_q;
    logic               perr_q;
    logic               ferr_q;
    logic               ovr_q;
    logic               busy_q;

    assign rx_s = rx_sync[1];

    // Two-flop synchronizer plus one flop of history for falling-edge detection
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], bus.RX};
            rx_prev <= rx_s;
        end
    end

    // Free-running 16x baud tick generator
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick    = (div_cnt == DIV_W'(DIV - 1));
    assign decide  = tick && (phase == PH_W'(DECIDE_PH));
    assign bit_end = tick && (phase == PH_W'(LAST_PH));
    assign par_ok  = (PARITY == 0) ? 1'b1 : (par_bit == ((^shreg) ^ PAR_ODD));

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic s7;
    logic s8;

    // Early samples held for the vote taken at tick 9
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            s7 <= 1'b1;
            s8 <= 1'b1;
        end else if (tick) begin
            if (phase == PH_W'(7)) s7 <= rx_s;
            if (phase == PH_W'(8)) s8 <= rx_s;
        end
    end

    assign bit_val = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // State register
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_next  = ST_START;
                    frame_start = 1'b1;
                end
            end
            ST_START: begin
                if (decide && bit_val) begin
                    state_next = ST_IDLE;
                end else if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt == CNT_W'(DATA_BITS - 1))) begin
                    state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    state_next = bit_val ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bit timing, payload capture and end-of-frame verdict
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            phase     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            done_good <= 1'b0;
            done_perr <= 1'b0;
            done_ferr <= 1'b0;
        end else begin
            done_good <= 1'b0;
            done_perr <= 1'b0;
            done_ferr <= 1'b0;
            if (frame_start) begin
                phase   <= '0;
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (tick) begin
                phase <= phase + PH_W'(1);
            end
            if (decide) begin
                case (state)
                    ST_DATA:   shreg[bit_cnt] <= bit_val;
                    ST_PARITY: par_bit <= bit_val;
                    ST_STOP: begin
                        done_good <= bit_val & par_ok;
                        done_perr <= bit_val & ~par_ok;
                        done_ferr <= ~bit_val;
                    end
                    default: ;
                endcase
            end
            if (bit_end && (state == ST_DATA)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Holding register, acknowledge and status pulses (completion cycle)
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            perr_q <= done_perr;
            ferr_q <= done_ferr;
            ovr_q  <= done_good & valid_q & ~bus.DATA_ACK;
            busy_q <= (state_next != ST_IDLE);
            if (done_good) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (bus.DATA_ACK) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.DATA       = data_q;
    assign bus.DATA_VALID = valid_q;
    assign bus.PARITY_ERR = perr_q;
    assign bus.FRAME_ERR  = ferr_q;
    assign bus.OVERRUN    = ovr_q;
    assign bus.BUSY       = busy_q;

endmodule
